end_screen_ctrl: RTL and testbench
==================================

# end_screen_ctrl

Frame-paced sequencer for the game-over overlay. Latches the end-of-game event, then steps the end-screen overlay through reveal, a blinking prompt and key wait. It drives the per-layer visibility enables and the high-score blink gate consumed by the end-screen bitmaps. It issues a held restart or credit request to the game-state logic and returns to idle on acknowledge.

## Interface
- REVEAL_FRAMES, 60: frames between game end and key prompts appearing (1..1023).
- BLINK_FRAMES, 16: half-period, in frames, of the banner/prompt blink (1..255).
- TIMEOUT_FRAMES, 1800: frames in PROMPT with no key before the attract request (1..65535).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- gameEnded  in  1  level; high while the game is over.
- newHighScore  in  1  level; sampled on the gameEnded rising edge.
- keyStart  in  1  one-cycle pulse, start key pressed.
- keyCredit  in  1  one-cycle pulse, credit key pressed.
- reqAck  in  1  one-cycle pulse from game-state logic accepting the pending request.
- endScreenEn  out  1  whole overlay visible.
- gameOverVis  out  1  "game over" banner layer enable.
- promptVis  out  1  start/credit key bitmap layer enable.
- highScoreBlink  out  1  banner high-score variant gate.
- restartReq  out  1  held request: start new game.
- creditReq  out  1  held request: insert credit.
- attractReq  out  1  held request: return to attract/start screen.

## Operation
- States: IDLE, REVEAL, PROMPT, REQ.
- frameCnt is 16 bits. It clears on every state entry and increments on each startOfFrame while in REVEAL or PROMPT. It saturates at 0xFFFF.
- blinkCnt is 8 bits and blinkPh is 1 bit, used in PROMPT only. On each startOfFrame, if blinkCnt == BLINK_FRAMES-1, blinkCnt clears and blinkPh toggles. Otherwise blinkCnt increments.
- hsLatch captures newHighScore on the IDLE->REVEAL transition and holds until IDLE.
- IDLE: all outputs low. The rising edge of gameEnded (registered previous value low, current high) moves to REVEAL.
- REVEAL:
  - endScreenEn=1, gameOverVis=1, promptVis=0, highScoreBlink=hsLatch.
  - Keys are ignored.
  - When frameCnt == REVEAL_FRAMES-1 and startOfFrame is asserted, move to PROMPT with blinkPh=1 and blinkCnt=0.
- PROMPT:
  - endScreenEn=1, gameOverVis=1, promptVis=blinkPh, highScoreBlink=hsLatch & blinkPh.
  - keyStart moves to REQ with restartReq=1.
  - Otherwise keyCredit moves to REQ with creditReq=1. keyStart wins when both arrive in the same cycle.
  - Otherwise, when frameCnt == TIMEOUT_FRAMES-1 and startOfFrame is asserted, move to REQ with attractReq=1.
- REQ:
  - endScreenEn=1, gameOverVis=1, promptVis=1, highScoreBlink=hsLatch.
  - Exactly one request line is high. It stays high until reqAck.
  - Further key pulses are ignored.
  - reqAck moves to IDLE, and all request lines drop in the same edge.
- gameEnded falling in any non-IDLE state forces IDLE on the next edge. Pending requests are dropped. This abort takes priority over key, timeout and reqAck in the same cycle.
- A key press after the IDLE return issues no request until a new gameEnded rising edge.
- reqAck outside REQ is ignored.

## Timing
- All outputs are registered and update on the clk rising edge after the causing input is sampled (1-cycle latency).
- Reset:
  - Synchronous. Takes effect on the first clk edge with reset=1.
  - State=IDLE. frameCnt, blinkCnt, blinkPh, hsLatch and the gameEnded edge register are all 0.
  - Every output is 0 in the cycle after the reset edge.
  - Reset mid-REQ drops the request with no ack required.
- If gameEnded is already high when reset releases, no sequence starts. A real low->high edge is required.
- REVEAL lasts exactly REVEAL_FRAMES startOfFrame pulses. The PROMPT timeout is exactly TIMEOUT_FRAMES pulses, counted from PROMPT entry.
- A startOfFrame coincident with a state transition is consumed by the transition. It does not also count in the new state.
- Request lines are mutually exclusive (one-hot or zero) in every cycle.

## Test plan
- Reset then entry: hold reset 3 cycles, then raise gameEnded with newHighScore=1 and REVEAL_FRAMES=4. Outputs are all 0 during reset. One cycle after the edge: endScreenEn=1, gameOverVis=1, highScoreBlink=1, promptVis=0. After the 4th startOfFrame: promptVis=1.
- Blink: with BLINK_FRAMES=2 in PROMPT, feed 8 frames. promptVis follows 1,1,0,0,1,1,0,0 per frame. highScoreBlink tracks it when hsLatch=1 and stays 0 when hsLatch=0.
- Key request handshake: in PROMPT, pulse keyStart and keyCredit in the same cycle. The next cycle shows restartReq=1, creditReq=0. Hold for 10 cycles with a keyCredit pulse in between: no change. Pulse reqAck: next cycle shows all outputs 0 and state IDLE.
- Timeout: TIMEOUT_FRAMES=5 with no keys in PROMPT. attractReq rises exactly one cycle after the 5th startOfFrame. It holds until reqAck.
- Abort: drop gameEnded while in REQ with creditReq high, and pulse reqAck in the same cycle. Next cycle shows all outputs 0. A subsequent keyStart produces no request.
- Reset mid-operation: assert reset for 1 cycle during REVEAL with gameEnded still high. Next cycle shows outputs 0 and state IDLE, and the sequence does not restart until gameEnded toggles low then high.

Source files
------------

// File: rtl/end_screen_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | end_screen_ctrl : frame-paced game-over overlay sequencer with blink,  |
// |                   key wait, held restart/credit/attract requests       |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module end_screen_ctrl #(
    parameter int REVEAL_FRAMES  = 60,
    parameter int BLINK_FRAMES   = 16,
    parameter int TIMEOUT_FRAMES = 1800
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic gameEnded,
    input  logic newHighScore,
    input  logic keyStart,
    input  logic keyCredit,
    input  logic reqAck,
    output logic endScreenEn,
    output logic gameOverVis,
    output logic promptVis,
    output logic highScoreBlink,
    output logic restartReq,
    output logic creditReq,
    output logic attractReq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REVEAL = 2'd1,
        S_PROMPT = 2'd2,
        S_REQ    = 2'd3
    } state_t;

    localparam logic [15:0] c_reveal_last  = 16'(REVEAL_FRAMES - 1);
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_FRAMES - 1);
    localparam logic [7:0]  c_blink_last   = 8'(BLINK_FRAMES - 1);

    state_t      state_q, state_d;
    logic [15:0] frameCnt_q, frameCnt_d;
    logic [7:0]  blinkCnt_q, blinkCnt_d;
    logic        blinkPh_q, blinkPh_d;
    logic        hsLatch_q, hsLatch_d;
    logic        restart_q, restart_d;
    logic        credit_q, credit_d;
    logic        attract_q, attract_d;
    logic        gePrev_q;
    logic        armed_q;
    logic        esEn_q, pVis_q, hsBlink_q;

    logic        w_rise;
    logic [15:0] w_frameInc;
    logic        w_esEn_d, w_pVis_d, w_hsBlink_d;

    // A rising edge only counts once gameEnded has been seen low since reset,
    // so a level already high at reset release never starts a sequence.
    assign w_rise     = gameEnded & ~gePrev_q & armed_q;
    assign w_frameInc = (frameCnt_q == 16'hFFFF) ? frameCnt_q : frameCnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        frameCnt_d = frameCnt_q;
        blinkCnt_d = blinkCnt_q;
        blinkPh_d  = blinkPh_q;
        hsLatch_d  = hsLatch_q;
        restart_d  = restart_q;
        credit_d   = credit_q;
        attract_d  = attract_q;

        if (state_q != S_IDLE && !gameEnded) begin
            state_d    = S_IDLE;
            frameCnt_d = 16'd0;
            blinkCnt_d = 8'd0;
            blinkPh_d  = 1'b0;
            hsLatch_d  = 1'b0;
            restart_d  = 1'b0;
            credit_d   = 1'b0;
            attract_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_rise) begin
                        state_d    = S_REVEAL;
                        frameCnt_d = 16'd0;
                        hsLatch_d  = newHighScore;
                    end
                end
                S_REVEAL: begin
                    if (startOfFrame) begin
                        if (frameCnt_q == c_reveal_last) begin
                            state_d    = S_PROMPT;
                            frameCnt_d = 16'd0;
                            blinkCnt_d = 8'd0;
                            blinkPh_d  = 1'b1;
                        end else begin
                            frameCnt_d = w_frameInc;
                        end
                    end
                end
                S_PROMPT: begin
                    if (keyStart) begin
                        state_d    = S_REQ;
                        frameCnt_d = 16'd0;
                        restart_d  = 1'b1;
                    end else if (keyCredit) begin
                        state_d    = S_REQ;
                        frameCnt_d = 16'd0;
                        credit_d   = 1'b1;
                    end else if (startOfFrame) begin
                        if (frameCnt_q == c_timeout_last) begin
                            state_d    = S_REQ;
                            frameCnt_d = 16'd0;
                            attract_d  = 1'b1;
                        end else begin
                            frameCnt_d = w_frameInc;
                            if (blinkCnt_q == c_blink_last) begin
                                blinkCnt_d = 8'd0;
                                blinkPh_d  = ~blinkPh_q;
                            end else begin
                                blinkCnt_d = blinkCnt_q + 8'd1;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (reqAck) begin
                        state_d    = S_IDLE;
                        frameCnt_d = 16'd0;
                        blinkCnt_d = 8'd0;
                        blinkPh_d  = 1'b0;
                        hsLatch_d  = 1'b0;
                        restart_d  = 1'b0;
                        credit_d   = 1'b0;
                        attract_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Visibility outputs are decoded from next-state values so they register alongside the state.
    assign w_esEn_d    = (state_d != S_IDLE);
    assign w_pVis_d    = (state_d == S_PROMPT) ? blinkPh_d : (state_d == S_REQ);
    assign w_hsBlink_d = (state_d == S_IDLE)   ? 1'b0 :
                         (state_d == S_PROMPT) ? (hsLatch_d & blinkPh_d) : hsLatch_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            frameCnt_q <= 16'd0;
            blinkCnt_q <= 8'd0;
            blinkPh_q  <= 1'b0;
            hsLatch_q  <= 1'b0;
            restart_q  <= 1'b0;
            credit_q   <= 1'b0;
            attract_q  <= 1'b0;
            gePrev_q   <= 1'b0;
            armed_q    <= 1'b0;
            esEn_q     <= 1'b0;
            pVis_q     <= 1'b0;
            hsBlink_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frameCnt_q <= frameCnt_d;
            blinkCnt_q <= blinkCnt_d;
            blinkPh_q  <= blinkPh_d;
            hsLatch_q  <= hsLatch_d;
            restart_q  <= restart_d;
            credit_q   <= credit_d;
            attract_q  <= attract_d;
            gePrev_q   <= gameEnded;
            armed_q    <= armed_q | ~gameEnded;
            esEn_q     <= w_esEn_d;
            pVis_q     <= w_pVis_d;
            hsBlink_q  <= w_hsBlink_d;
        end
    end

    assign endScreenEn    = esEn_q;
    assign gameOverVis    = esEn_q;
    assign promptVis      = pVis_q;
    assign highScoreBlink = hsBlink_q;
    assign restartReq     = restart_q;
    assign creditReq      = credit_q;
    assign attractReq     = attract_q;

endmodule
`default_nettype wire

// File: tb/tb_end_screen_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_end_screen_ctrl : vector table, directed corner sequences and       |
// |                      random traffic against a frame-level model        |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_end_screen_ctrl;

    localparam int REVEAL  = 4;
    localparam int BLINK   = 2;
    localparam int TIMEOUT = 10;

    logic clk = 1'b0;
    logic reset = 1'b1, sof = 1'b0, ge = 1'b0, nhs = 1'b0;
    logic ks = 1'b0, kc = 1'b0, ack = 1'b0;
    logic endScreenEn, gameOverVis, promptVis, highScoreBlink;
    logic restartReq, creditReq, attractReq;
    logic [6:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    end_screen_ctrl #(
        .REVEAL_FRAMES (REVEAL),
        .BLINK_FRAMES  (BLINK),
        .TIMEOUT_FRAMES(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (sof),
        .gameEnded     (ge),
        .newHighScore  (nhs),
        .keyStart      (ks),
        .keyCredit     (kc),
        .reqAck        (ack),
        .endScreenEn   (endScreenEn),
        .gameOverVis   (gameOverVis),
        .promptVis     (promptVis),
        .highScoreBlink(highScoreBlink),
        .restartReq    (restartReq),
        .creditReq     (creditReq),
        .attractReq    (attractReq)
    );

    assign outs = {endScreenEn, gameOverVis, promptVis, highScoreBlink,
                   restartReq, creditReq, attractReq};

    // Frame-level reference: which screen phase, frames seen in it, which request is pending.
    localparam int M_IDLE = 0, M_REVEAL = 1, M_PROMPT = 2, M_REQ = 3;
    int m_mode = M_IDLE, m_frames = 0, m_req = 0;
    bit m_hs = 0, m_prev = 0, m_armed = 0;

    task automatic model_step();
        bit rise;
        if (reset) begin
            m_mode = M_IDLE; m_frames = 0; m_req = 0; m_hs = 0; m_prev = 0; m_armed = 0;
            return;
        end
        rise = ge && !m_prev && m_armed;
        if (m_mode != M_IDLE && !ge) begin
            m_mode = M_IDLE; m_req = 0; m_hs = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (rise) begin m_mode = M_REVEAL; m_frames = 0; m_hs = nhs; end
                M_REVEAL: if (sof) begin
                    m_frames++;
                    if (m_frames == REVEAL) begin m_mode = M_PROMPT; m_frames = 0; end
                end
                M_PROMPT: begin
                    if (ks) begin m_mode = M_REQ; m_req = 1; end
                    else if (kc) begin m_mode = M_REQ; m_req = 2; end
                    else if (sof) begin
                        m_frames++;
                        if (m_frames == TIMEOUT) begin m_mode = M_REQ; m_req = 3; end
                    end
                end
                default: if (ack) begin m_mode = M_IDLE; m_req = 0; m_hs = 0; end
            endcase
        end
        m_prev = ge;
        if (!ge) m_armed = 1;
    endtask

    function automatic logic [6:0] model_outs();
        bit ph;
        ph = ((m_frames / BLINK) % 2) == 0;
        case (m_mode)
            M_REVEAL: return {1'b1, 1'b1, 1'b0, m_hs, 3'b000};
            M_PROMPT: return {1'b1, 1'b1, ph, m_hs & ph, 3'b000};
            M_REQ:    return {1'b1, 1'b1, 1'b1, m_hs, m_req == 1, m_req == 2, m_req == 3};
            default:  return 7'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: the edge samples the current inputs, then outputs are compared and pulses cleared.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", outs, model_outs());
        sof = 1'b0; ks = 1'b0; kc = 1'b0; ack = 1'b0;
    endtask

    task automatic start_seq(input logic hs);
        ge = 1'b0; tick();
        ge = 1'b1; nhs = hs; tick();
        nhs = 1'b0;
        repeat (REVEAL) begin sof = 1'b1; tick(); end
    endtask

    typedef struct packed {
        logic       rst, sof, ge, nhs, ks, kc, ack;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r, s, g, n, k1, k2, a, input logic [6:0] e);
        return {r, s, g, n, k1, k2, a, e};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[20];
        //              rst sof ge nhs ks kc ack  {es,go,pv,hb,rr,cr,ar}
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 7'b0000000);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 7'b0000000);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 7'b0000000);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000);
        vecs[4]  = mk(0, 0, 1, 1, 0, 0, 0, 7'b1101000);
        vecs[5]  = mk(0, 1, 1, 0, 0, 0, 0, 7'b1101000);
        vecs[6]  = mk(0, 0, 1, 0, 1, 0, 0, 7'b1101000);
        vecs[7]  = mk(0, 1, 1, 0, 0, 0, 0, 7'b1101000);
        vecs[8]  = mk(0, 1, 1, 0, 0, 0, 0, 7'b1101000);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0, 0, 7'b1111000);
        vecs[10] = mk(0, 1, 1, 0, 0, 0, 0, 7'b1111000);
        vecs[11] = mk(0, 1, 1, 0, 0, 0, 0, 7'b1100000);
        vecs[12] = mk(0, 0, 1, 0, 0, 0, 0, 7'b1100000);
        vecs[13] = mk(0, 1, 1, 0, 0, 0, 0, 7'b1100000);
        vecs[14] = mk(0, 1, 1, 0, 0, 0, 0, 7'b1111000);
        vecs[15] = mk(0, 0, 1, 0, 1, 1, 0, 7'b1111100);
        vecs[16] = mk(0, 0, 1, 0, 0, 1, 0, 7'b1111100);
        vecs[17] = mk(0, 1, 1, 0, 0, 0, 0, 7'b1111100);
        vecs[18] = mk(0, 0, 1, 0, 0, 0, 1, 7'b0000000);
        vecs[19] = mk(0, 0, 1, 0, 1, 0, 0, 7'b0000000);

        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst; sof = vecs[i].sof; ge = vecs[i].ge; nhs = vecs[i].nhs;
            ks = vecs[i].ks; kc = vecs[i].kc; ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i), outs, vecs[i].exp);
        end

        // Blink with no high score: prompt follows 1,1,0,0,... and the gate stays low.
        start_seq(1'b0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("blink_pv%0d", k), {6'b0, promptVis}, {6'b0, ((k / BLINK) % 2) == 0});
            check($sformatf("blink_hs%0d", k), {6'b0, highScoreBlink}, 7'b0);
            sof = 1'b1; tick();
        end

        // Timeout: attract rises exactly after the TIMEOUT-th frame and holds until ack.
        start_seq(1'b1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            sof = 1'b1; tick();
            check($sformatf("timeout%0d", k), {6'b0, attractReq}, {6'b0, k == TIMEOUT});
        end
        repeat (3) begin sof = 1'b1; kc = 1'b1; tick(); end
        check("attract_hold", outs, 7'b1111001);
        ack = 1'b1; tick();
        check("attract_ack", outs, 7'b0000000);

        // Abort beats ack in REQ; a later key does nothing.
        start_seq(1'b0);
        kc = 1'b1; tick();
        check("credit_req", outs, 7'b1110010);
        ge = 1'b0; ack = 1'b1; tick();
        check("abort", outs, 7'b0000000);
        ks = 1'b1; tick();
        check("key_after_abort", outs, 7'b0000000);

        // Reset mid-REVEAL with gameEnded held high needs a fresh low->high edge.
        ge = 1'b1; nhs = 1'b1; tick();
        nhs = 1'b0;
        check("reveal_entry", outs, 7'b1101000);
        repeat (2) begin sof = 1'b1; tick(); end
        reset = 1'b1; tick();
        check("reset_mid", outs, 7'b0000000);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sof = 1'b1; ks = 1'b1; tick();
            check($sformatf("no_restart%0d", k), outs, 7'b0000000);
        end
        ge = 1'b0; tick();
        ge = 1'b1; nhs = 1'b1; tick();
        nhs = 1'b0;
        check("restart_after_toggle", outs, 7'b1101000);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) ge = ~ge;
            nhs = 1'($urandom_range(0, 1));
            sof = ($urandom_range(0, 2) == 0);
            ks  = ($urandom_range(0, 39) == 0);
            kc  = ($urandom_range(0, 39) == 0);
            ack = ($urandom_range(0, 7) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
